rib_wait_bridge: RTL and testbench

//   Adapter between one req/ready slave port of the RIB interconnect (slots 3/6/7)
//   and a slow word-wide memory/peripheral that answers with a one-cycle ack.

---
 rtl/rib_wait_bridge.sv | 96 +++++++++
 tb/tb_rib_wait_bridge.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rib_wait_bridge.sv
// rib_wait_bridge: RIB req/ready slave to one-cycle-ack memory adapter with wait timeout
module rib_wait_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 14,
  parameter int TIMEOUT = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_req_i,
  input  logic              s_we_i,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, err_q, err_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic unused_addr;
  assign unused_addr = ^{s_addr_i[ADDR_W-1:MEM_AW+2], s_addr_i[1:0]};
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d = cnt_q;
    err_d = err_clr_i ? 1'b0 : err_q;
    unique case (state_q)
      IDLE: if (s_req_i) begin
        we_d = s_we_i;
        addr_d = s_addr_i[MEM_AW+1:2];
        wdata_d = s_data_i;
        state_d = CMD;
      end
      CMD: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (mem_ack_i) begin
        rdata_d = we_q ? '0 : mem_rdata_i;
        state_d = RESP;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        rdata_d = we_q ? '0 : ERR_DATA;
        err_d = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign mem_req_o = state_q == CMD;
  assign mem_we_o = state_q == CMD ? we_q : 1'b0;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign s_ready_o = state_q == RESP;
  assign s_data_o = state_q == RESP ? rdata_q : '0;
  assign busy_o = state_q != IDLE;
  assign err_o = err_q;
endmodule

// File: tb/tb_rib_wait_bridge.sv
// tb_rib_wait_bridge: directed checks of rib_wait_bridge with default and short timeouts
module tb_rib_wait_bridge;
  logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
  logic s_req = 1'b0, s_we = 1'b0, ack = 1'b0, err_clr = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0, rdata = '0;
  logic [31:0] a_data, b_data, a_wd, b_wd;
  logic [13:0] a_addr, b_addr;
  logic a_rdy, b_rdy, a_req, b_req, a_we, b_we, a_busy, b_busy, a_err, b_err;
  logic [31:0] o_data, o_wd;
  logic [13:0] o_addr;
  logic o_rdy, o_req, o_we, o_busy, o_err;
  int errors = 0, checks = 0, n_req = 0, n_rdy = 0, s_req0, s_rdy0;
  always #5 clk = ~clk;
  rib_wait_bridge dut_a (
    .clk(clk), .rst_n(rst_n), .s_req_i(s_req & ~sel), .s_we_i(s_we), .s_addr_i(s_addr),
    .s_data_i(s_wdata), .s_data_o(a_data), .s_ready_o(a_rdy), .mem_req_o(a_req), .mem_we_o(a_we),
    .mem_addr_o(a_addr), .mem_wdata_o(a_wd), .mem_rdata_i(rdata), .mem_ack_i(ack & ~sel),
    .busy_o(a_busy), .err_o(a_err), .err_clr_i(err_clr)
  );
  rib_wait_bridge #(.TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_req_i(s_req & sel), .s_we_i(s_we), .s_addr_i(s_addr),
    .s_data_i(s_wdata), .s_data_o(b_data), .s_ready_o(b_rdy), .mem_req_o(b_req), .mem_we_o(b_we),
    .mem_addr_o(b_addr), .mem_wdata_o(b_wd), .mem_rdata_i(rdata), .mem_ack_i(ack & sel),
    .busy_o(b_busy), .err_o(b_err), .err_clr_i(err_clr)
  );
  assign o_data = sel ? b_data : a_data;
  assign o_wd = sel ? b_wd : a_wd;
  assign o_addr = sel ? b_addr : a_addr;
  assign o_rdy = sel ? b_rdy : a_rdy;
  assign o_req = sel ? b_req : a_req;
  assign o_we = sel ? b_we : a_we;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_err = sel ? b_err : a_err;
  always @(negedge clk) begin
    n_req <= n_req + int'(o_req);
    n_rdy <= n_rdy + int'(o_rdy);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick; tick;
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_ready", {31'b0, o_rdy}, 0);
    chk("rst_memreq", {31'b0, o_req}, 0);
    chk("rst_err", {31'b0, o_err}, 0);
    chk("rst_data", o_data, 0);
    chk("rst_addr", {18'b0, o_addr}, 0);
    rst_n = 1'b1;
    tick;
    s_req = 1'b1; s_we = 1'b0; s_addr = 32'h6000_0010;
    tick;
    chk("t1_memreq", {31'b0, o_req}, 1);
    chk("t1_addr", {18'b0, o_addr}, 4);
    chk("t1_we", {31'b0, o_we}, 0);
    chk("t1_busy", {31'b0, o_busy}, 1);
    tick;
    chk("t1_req_one", {31'b0, o_req}, 0);
    ack = 1'b1; rdata = 32'h1234_5678;
    tick;
    ack = 1'b0;
    chk("t1_ready", {31'b0, o_rdy}, 1);
    chk("t1_data", o_data, 32'h1234_5678);
    s_req = 1'b0;
    tick;
    chk("t1_ready_end", {31'b0, o_rdy}, 0);
    chk("t1_data_zero", o_data, 0);
    chk("t1_idle", {31'b0, o_busy}, 0);
    s_req0 = n_req;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h6000_0020; s_wdata = 32'hA5A5_0F0F;
    tick;
    chk("t2_memreq", {31'b0, o_req}, 1);
    chk("t2_we", {31'b0, o_we}, 1);
    chk("t2_wdata", o_wd, 32'hA5A5_0F0F);
    chk("t2_addr", {18'b0, o_addr}, 8);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_ready", {31'b0, o_rdy}, 0);
      tick;
    end
    ack = 1'b1; rdata = 32'hFFFF_FFFF;
    tick;
    ack = 1'b0;
    chk("t2_ready", {31'b0, o_rdy}, 1);
    chk("t2_data", o_data, 0);
    s_req = 1'b0; s_we = 1'b0;
    tick;
    chk("t2_one_cmd", n_req - s_req0, 1);
    s_req0 = n_req; s_rdy0 = n_rdy;
    s_req = 1'b1; s_addr = 32'h6000_0100;
    tick;
    chk("t4_addr1", {18'b0, o_addr}, 32'h40);
    tick;
    s_addr = 32'h6000_0200;
    ack = 1'b1; rdata = 32'h1111_1111;
    chk("t4_addr_hold", {18'b0, o_addr}, 32'h40);
    tick;
    ack = 1'b0;
    chk("t4_ready1", {31'b0, o_rdy}, 1);
    chk("t4_data1", o_data, 32'h1111_1111);
    tick;
    chk("t4_gap_idle", {31'b0, o_busy}, 0);
    tick;
    chk("t4_memreq2", {31'b0, o_req}, 1);
    chk("t4_addr2", {18'b0, o_addr}, 32'h80);
    tick;
    ack = 1'b1; rdata = 32'h2222_2222;
    tick;
    ack = 1'b0;
    chk("t4_ready2", {31'b0, o_rdy}, 1);
    chk("t4_data2", o_data, 32'h2222_2222);
    s_req = 1'b0;
    tick;
    chk("t4_cmd_count", n_req - s_req0, 2);
    chk("t4_rdy_count", n_rdy - s_rdy0, 2);
    s_rdy0 = n_rdy;
    s_req = 1'b1; s_addr = 32'h6000_0044;
    tick; tick;
    chk("t5_in_wait", {31'b0, o_busy}, 1);
    s_req = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1; ack = 1'b1; rdata = 32'h3333_3333;
    chk("t5_busy", {31'b0, o_busy}, 0);
    chk("t5_addr", {18'b0, o_addr}, 0);
    chk("t5_memreq", {31'b0, o_req}, 0);
    tick;
    ack = 1'b0;
    chk("t5_no_ready", {31'b0, o_rdy}, 0);
    chk("t5_still_idle", {31'b0, o_busy}, 0);
    tick;
    chk("t5_rdy_count", n_rdy - s_rdy0, 0);
    sel = 1'b1;
    s_req = 1'b1; s_addr = 32'h6000_0030;
    tick;
    chk("t3_memreq", {31'b0, o_req}, 1);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("t3_wait_ready", {31'b0, o_rdy}, 0);
      chk("t3_wait_err", {31'b0, o_err}, 0);
      tick;
    end
    chk("t3_ready", {31'b0, o_rdy}, 1);
    chk("t3_data", o_data, 32'hDEAD_BEEF);
    chk("t3_err", {31'b0, o_err}, 1);
    s_req = 1'b0;
    tick;
    chk("t3_err_sticky", {31'b0, o_err}, 1);
    chk("t3_idle", {31'b0, o_busy}, 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("t3_err_clr", {31'b0, o_err}, 0);
    s_req = 1'b1; s_addr = 32'h6000_0050;
    tick; tick;
    for (int i = 0; i < 3; i++) tick;
    ack = 1'b1; rdata = 32'hCAFE_F00D;
    tick;
    ack = 1'b0;
    chk("t6_ready", {31'b0, o_rdy}, 1);
    chk("t6_data", o_data, 32'hCAFE_F00D);
    chk("t6_no_err", {31'b0, o_err}, 0);
    s_req = 1'b0;
    tick;
    chk("t6_idle", {31'b0, o_busy}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
